// File: rtl/serial_adder_pkg.sv
// Shared types and elaboration helpers for the multi-cycle serial adder.
package serial_adder_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   // Bit k set means a CHUNK of k bits is a supported slice width.
   localparam logic [15:0] CHUNK_LEGAL_MASK = 16'h0116;

   function automatic bit chunk_legal(input int chunk, input int width);
      if (chunk < 1 || chunk > 8 || chunk > width) return 1'b0;
      if ((width % chunk) != 0) return 1'b0;
      return CHUNK_LEGAL_MASK[chunk[3:0]];
   endfunction

   function automatic int step_cnt_width(input int nstep);
      return (nstep <= 1) ? 1 : $clog2(nstep);
   endfunction

endpackage

// File: rtl/serial_adder_add_chunk.sv
// CHUNK-bit combinational ripple slice built from 1-bit full adders;
// also exposes the carry into its top bit for signed-overflow detection.
module add_chunk #(
   parameter int CHUNK = 1
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             cin,
   output logic [CHUNK-1:0] s,
   output logic             cout,
   output logic             cmsb
);

   logic [CHUNK:0] c;

   assign c[0] = cin;

   for (genvar i = 0; i < CHUNK; i++) begin : g_bit
      fullAdder_1b u_fa (
         .a    (a[i]),
         .b    (b[i]),
         .cin  (c[i]),
         .s    (s[i]),
         .cout (c[i+1])
      );
   end

   assign cout = c[CHUNK];
   assign cmsb = c[CHUNK-1];

endmodule

module fullAdder_1b (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder: WIDTH-bit a + b + c_in, CHUNK bits per clock via one ripple slice.
// Define SERIAL_ADDER_SUB_EN to add a 'sub' input selecting a - b.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CHUNK = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
`ifdef SERIAL_ADDER_SUB_EN
   input  logic             sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             c_out,
   output logic             ofl
);

   localparam int NSTEP = WIDTH / CHUNK;
   localparam int CNT_W = step_cnt_width(NSTEP);
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(NSTEP - 1);

   if (!chunk_legal(CHUNK, WIDTH)) begin : g_bad_chunk
      $error("serial_adder: CHUNK must be 1, 2, 4 or 8 and divide WIDTH");
   end

   state_t           state;
   logic [CNT_W-1:0] step;
   logic             carry;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] acc_sr;
   logic [WIDTH-1:0] acc_next;
   logic [WIDTH-1:0] b_eff;
   logic             carry_init;
   logic [CHUNK-1:0] slice_s;
   logic             slice_cout;
   logic             slice_cmsb;

`ifdef SERIAL_ADDER_SUB_EN
   // Subtraction is a + ~b + 1, so c_in is overridden by a forced carry.
   assign b_eff      = sub ? ~b : b;
   assign carry_init = sub ? 1'b1 : c_in;
`else
   assign b_eff      = b;
   assign carry_init = c_in;
`endif

   add_chunk #(.CHUNK(CHUNK)) u_slice (
      .a    (a_sr[CHUNK-1:0]),
      .b    (b_sr[CHUNK-1:0]),
      .cin  (carry),
      .s    (slice_s),
      .cout (slice_cout),
      .cmsb (slice_cmsb)
   );

   // Slices enter at the top, so after NSTEP shifts the first slice sits at bit 0.
   assign acc_next = WIDTH'({slice_s, acc_sr} >> CHUNK);
   assign busy     = (state == RUN);

   // NOTE: every register, datapath shift registers included, takes the async reset
   // so the outputs and the next operation never see stale or X contents.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         step   <= '0;
         carry  <= 1'b0;
         a_sr   <= '0;
         b_sr   <= '0;
         acc_sr <= '0;
         sum    <= '0;
         c_out  <= 1'b0;
         ofl    <= 1'b0;
         done   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments throughout, so every register samples
         // pre-edge values regardless of statement order.
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  a_sr  <= a;
                  b_sr  <= b_eff;
                  carry <= carry_init;
                  step  <= '0;
                  state <= RUN;
               end
            end
            RUN: begin
               acc_sr <= acc_next;
               carry  <= slice_cout;
               a_sr   <= a_sr >> CHUNK;
               b_sr   <= b_sr >> CHUNK;
               step   <= step + CNT_W'(1);
               if (step == LAST_STEP) begin
                  state <= IDLE;
                  sum   <= acc_next;
                  c_out <= slice_cout;
                  ofl   <= slice_cmsb ^ slice_cout;
                  done  <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
